// File: rtl/soc_simple_pio_in_irq.sv
// soc_simple_pio_in_irq
//   Avalon-MM parallel input port with synchronisers, optional per-bit
//   debounce, edge capture and a maskable interrupt.
//
// Ports
//   clk        - single clock, all state on its rising edge
//   reset_n    - asynchronous active-low reset
//   address    - 2-bit word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect - slave select; a write is chipselect=1 with write_n=0
//   write_n    - active-low write strobe
//   writedata  - write data (bits at or above WIDTH ignored)
//   in_port    - asynchronous external inputs
//   readdata   - registered read data, one cycle after address, upper bits 0
//   irq        - registered active-high interrupt request

module soc_simple_pio_in_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Cycles the input front end needs after reset before the stable value
    // reflects the pins; edge capture is held off until then so inputs that
    // are already high when reset releases do not look like edges.
    localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int SW     = $clog2(SETTLE + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    cnt_q [WIDTH];
            logic [CW-1:0]    cnt_d [WIDTH];
            logic [WIDTH-1:0] stable_q;
            logic [WIDTH-1:0] stable_d;

            // Counter holds the number of disagreeing cycles already seen;
            // the cycle that would make it DEBOUNCE_CYCLES adopts the value.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (sync_out[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            stable_d[i] = sync_out[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= '0;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign stable = stable_q;
        end else begin : g_nodb
            assign stable = sync_out;
        end

        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0] delayed_q, delayed_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        delayed_d = stable;
        settle_d  = (settle_q == '0) ? '0 : settle_q - SW'(1);

        if (EDGE_TYPE == 0) begin
            edge_hit = stable & ~delayed_q;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~stable & delayed_q;
        end else begin
            edge_hit = stable ^ delayed_q;
        end
        if (settle_q != '0) edge_hit = '0;

        mask_d = mask_q;
        if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];

        cap_clr = '0;
        if (wr_en && address == 2'd3) cap_clr = writedata[WIDTH-1:0];
        // New edges are ORed in after the clear so a coincident edge survives.
        cap_d = (cap_q & ~cap_clr) | edge_hit;

        if (IRQ_TYPE == 1) begin
            irq_d = |(cap_q & mask_q);
        end else begin
            irq_d = |(stable & mask_q);
        end

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delayed_q  <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            settle_q   <= SW'(SETTLE);
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            delayed_q  <= delayed_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            settle_q   <= settle_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
